// File: rtl/prog_sequencer.sv
// Fetch/execute state sequencer driving the control-unit state code.
// Optional retired-instruction counter: define SEQ_INSTR_COUNT_EN.
module prog_sequencer #(
  parameter int IR_WIDTH     = 16,
  parameter int OPCODE_WIDTH = 6,
  parameter int STATE_WIDTH  = 6,
  parameter int WAIT_TIMEOUT = 15,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [IR_WIDTH-1:0]    IR,
  input  logic                   z_flag,
  input  logic                   mem_wait,
  output logic [STATE_WIDTH-1:0] state,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  localparam int WCW = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE   = STATE_WIDTH'(0),  FETCH1 = STATE_WIDTH'(1),  FETCH2 = STATE_WIDTH'(2),
    FETCH3 = STATE_WIDTH'(3),  CLAC   = STATE_WIDTH'(4),  LDAC1  = STATE_WIDTH'(5),
    LDAC2  = STATE_WIDTH'(6),  LDAC3  = STATE_WIDTH'(7),  LDAC4  = STATE_WIDTH'(8),
    STAC1  = STATE_WIDTH'(9),  STAC2  = STATE_WIDTH'(10), STAC3  = STATE_WIDTH'(11),
    STAC4  = STATE_WIDTH'(12), MVACR  = STATE_WIDTH'(13), MVRAC  = STATE_WIDTH'(14),
    ADD    = STATE_WIDTH'(15), MUL    = STATE_WIDTH'(16), SUB    = STATE_WIDTH'(17),
    INCAC  = STATE_WIDTH'(18), JUMP1  = STATE_WIDTH'(19), JUMP2  = STATE_WIDTH'(20),
    JMPZY1 = STATE_WIDTH'(21), JMPZY2 = STATE_WIDTH'(22), JMPZN  = STATE_WIDTH'(23),
    END    = STATE_WIDTH'(24), ERROR  = STATE_WIDTH'(25)
  } state_t;

  state_t cur, nxt;
  logic [WCW-1:0] wait_cnt, wait_nxt;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic stall, boundary;
  logic unused_ir;

  assign opcode    = IR[IR_WIDTH-1 -: OPCODE_WIDTH];
  assign unused_ir = ^IR[IR_WIDTH-OPCODE_WIDTH-1:0];

  assign stall    = cur inside {FETCH2, LDAC2, LDAC3, STAC2, STAC3};
  assign boundary = cur inside {CLAC, LDAC4, STAC4, MVACR, MVRAC, ADD, MUL, SUB,
                                INCAC, JUMP2, JMPZY2, JMPZN};

  always_comb begin
    nxt      = cur;
    wait_nxt = '0;
    case (cur)
      IDLE:   if (start) nxt = FETCH1;
      FETCH1: nxt = FETCH2;
      FETCH2: nxt = FETCH3;
      FETCH3: begin
        case (int'(opcode))
          0:       nxt = END;
          1:       nxt = CLAC;
          2:       nxt = LDAC1;
          3:       nxt = STAC1;
          4:       nxt = MVACR;
          5:       nxt = MVRAC;
          6:       nxt = ADD;
          7:       nxt = MUL;
          8:       nxt = SUB;
          9:       nxt = INCAC;
          10:      nxt = JUMP1;
          11:      nxt = z_flag ? JMPZY1 : JMPZN;
          default: nxt = ERROR;
        endcase
      end
      LDAC1:  nxt = LDAC2;
      LDAC2:  nxt = LDAC3;
      LDAC3:  nxt = LDAC4;
      STAC1:  nxt = STAC2;
      STAC2:  nxt = STAC3;
      STAC3:  nxt = STAC4;
      JUMP1:  nxt = JUMP2;
      JMPZY1: nxt = JMPZY2;
      END:    nxt = IDLE;
      ERROR:  nxt = ERROR;
      default: if (!boundary) nxt = ERROR;
    endcase
    if (boundary) nxt = stop ? IDLE : FETCH1;
    // A stall holds the state; the counter only survives while the state is held.
    if (stall && mem_wait) begin
      if (WAIT_TIMEOUT != 0 && wait_cnt == WCW'(WAIT_TIMEOUT)) begin
        nxt = ERROR;
      end else begin
        nxt      = cur;
        wait_nxt = (WAIT_TIMEOUT != 0) ? wait_cnt + 1'b1 : '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur      <= IDLE;
      wait_cnt <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      cur      <= nxt;
      wait_cnt <= wait_nxt;
      done     <= (cur == END);
      error    <= error | (nxt == ERROR);
    end
  end

  assign state = cur;
  assign busy  = (cur != IDLE);

`ifdef SEQ_INSTR_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                    instr_count <= '0;
    else if (boundary || cur == END) instr_count <= instr_count + 1'b1;
  end
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: instruction-level traces feed an expected-state queue.
module tb_prog_sequencer;
  logic        clock = 0, reset = 1, start = 0, stop = 0, z_flag = 0, mem_wait = 0;
  logic [15:0] IR = '0;
  logic [5:0]  state;
  logic        busy, done, error;
  logic [15:0] instr_count;

  prog_sequencer #(.IR_WIDTH(16), .OPCODE_WIDTH(6), .STATE_WIDTH(6), .WAIT_TIMEOUT(15),
                   .COUNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .IR(IR), .z_flag(z_flag),
    .mem_wait(mem_wait), .state(state), .busy(busy), .done(done), .error(error),
    .instr_count(instr_count));

  always #5 clock = ~clock;

  typedef struct { int code; bit dn; bit er; int cnt; } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  bit done_m = 0, err_m = 0;
  int cnt_m = 0;

  task automatic chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic bit is_bnd(int c);
    return c inside {4, 8, 12, 13, 14, 15, 16, 17, 18, 20, 22, 23};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Monitor: compare whatever the DUT shows against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock); #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state", int'(state), e.code);
        chk("busy", int'(busy), int'(e.code != 0));
        chk("done", int'(done), int'(e.dn));
        chk("error", int'(error), int'(e.er));
`ifdef SEQ_INSTR_COUNT_EN
        chk("instr_count", int'(instr_count), e.cnt);
`else
        chk("instr_count", int'(instr_count), 0);
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // One cycle in which the DUT is expected to show state `code`.
  task automatic cyc(int code, bit mw, bit st, bit sa, bit zf);
    @(negedge clock);
    mem_wait = mw; stop = st; start = sa; z_flag = zf;
    if (code == 25) err_m = 1;
    q.push_back('{code, done_m, err_m, cnt_m});
    done_m = (code == 24);
    if (is_bnd(code) || code == 24) cnt_m = (cnt_m + 1) % 65536;
  endtask

  task automatic do_reset();
    @(negedge clock); #3;
    reset = 1; #1;
    chk("rst_state", int'(state), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_count", int'(instr_count), 0);
    @(negedge clock);
    reset = 0; start = 0; stop = 0; mem_wait = 0;
    done_m = 0; err_m = 0; cnt_m = 0;
  endtask

  // Runs one instruction from FETCH1. zsel: 0/1 forces z_flag, 2 = random.
  // outcome: 0 back to fetch, 1 to idle, 2 error.
  task automatic instr(int op, int fst, int mst, bit stp, int zsel, output int outcome);
    int body[$];
    bit z;
    logic [9:0] lo;
    lo = 10'($urandom);
    IR = {op[5:0], lo};
    z  = (zsel == 2) ? rb() : 1'(zsel);
    cyc(1, rb(), rb(), rb(), rb());
    repeat (fst) cyc(2, 1, rb(), rb(), rb());
    cyc(2, 0, rb(), rb(), rb());
    cyc(3, rb(), rb(), rb(), z);
    case (op)
      0: body = '{24};            1: body = '{4};
      2: body = '{5, 6, 7, 8};    3: body = '{9, 10, 11, 12};
      4: body = '{13};            5: body = '{14};
      6: body = '{15};            7: body = '{16};
      8: body = '{17};            9: body = '{18};
      10: body = '{19, 20};
      11: body = z ? '{21, 22} : '{23};
      default: body = '{25};
    endcase
    foreach (body[i]) begin
      if (body[i] == 6 || body[i] == 10) begin
        repeat (mst) cyc(body[i], 1, rb(), rb(), rb());
        cyc(body[i], 0, rb(), rb(), rb());
      end else if (body[i] == 7 || body[i] == 11) begin
        cyc(body[i], 0, rb(), rb(), rb());
      end else begin
        cyc(body[i], rb(), is_bnd(body[i]) ? stp : rb(), rb(), rb());
      end
    end
    if (body[$] == 24)      outcome = 1;
    else if (body[$] == 25) outcome = 2;
    else                    outcome = stp ? 1 : 0;
  endtask

  task automatic run_prog(int n);
    int op, r, oc;
    repeat ($urandom_range(0, 2)) cyc(0, rb(), rb(), 0, rb());
    cyc(0, rb(), rb(), 1, rb());
    for (int i = 0; i < n; i++) begin
      r  = $urandom_range(0, 19);
      op = (r < 12) ? r : (r < 19) ? $urandom_range(1, 11) : $urandom_range(12, 63);
      if (i == n - 1) op = 0;
      instr(op, $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 9) == 0),
            2, oc);
      if (oc == 2) begin
        repeat (3) cyc(25, rb(), rb(), rb(), rb());
        do_reset();
        return;
      end
      if (oc == 1) return;
    end
  endtask

  initial begin
    int oc;
    #2;
    chk("init_state", int'(state), 0);
    chk("init_busy", int'(busy), 0);
    chk("init_done", int'(done), 0);
    chk("init_error", int'(error), 0);
    @(negedge clock);
    reset = 0;

    // ADD then END: done pulse, two retired instructions
    cyc(0, 0, 0, 1, 0);
    instr(6, 0, 0, 0, 2, oc);
    instr(0, 0, 0, 0, 2, oc);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // LDAC with three stalled cycles in LDAC2, then JMPZ taken/not taken
    cyc(0, 0, 0, 1, 0);
    instr(2, 0, 3, 0, 2, oc);
    instr(11, 0, 0, 0, 1, oc);
    instr(11, 0, 0, 0, 0, oc);
    // stop during ADD returns to IDLE without done
    instr(6, 0, 0, 1, 2, oc);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Illegal opcode traps; start/stop ignored in ERROR
    cyc(0, 0, 0, 1, 0);
    instr(12, 0, 0, 0, 2, oc);
    cyc(25, 0, 1, 1, 0);
    cyc(25, 0, 0, 1, 0);
    do_reset();

    // Memory-wait timeout in FETCH2
    cyc(0, 0, 0, 1, 0);
    IR = 16'h1800;
    cyc(1, 0, 0, 0, 0);
    repeat (16) cyc(2, 1, 0, 0, 0);
    cyc(25, 1, 0, 1, 0);
    cyc(25, 0, 0, 1, 0);
    cyc(25, 0, 1, 0, 0);
    do_reset();

    // Reset mid-LDAC2 abandons the instruction with no done pulse
    cyc(0, 0, 0, 1, 0);
    IR = 16'h0800;
    cyc(1, 0, 0, 0, 0);
    cyc(2, 0, 0, 0, 0);
    cyc(3, 0, 0, 0, 0);
    cyc(5, 0, 0, 0, 0);
    cyc(6, 1, 0, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    repeat (60) run_prog($urandom_range(1, 8));

    repeat (3) @(negedge clock);
    chk("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
